// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port byte-addressable memory between the
//                instruction-fetch port and the load/store data port. Grants
//                one access per cycle, blocks faulting accesses from reaching
//                the memory, and returns read data one cycle after the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int                AWIDTH       = 32,
    parameter int                DWIDTH       = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR    = 32'h01000000,
    parameter int                MEM_BYTES    = 4096,
    parameter int                STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch port
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    output logic              if_err_o,
    // load/store data port
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic [2:0]        d_funct3_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic              d_err_o,
    // memory side
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    // Counter must be able to hold STARVE_LIMIT itself (it saturates there).
    localparam int              c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    // Range arithmetic is one bit wider so addr+3 near the top of the
    // address space cannot wrap into the valid window.
    localparam int              c_EW    = AWIDTH + 1;
    localparam logic [c_EW-1:0] c_LO    = {1'b0, BASE_ADDR};
    localparam logic [c_EW-1:0] c_HI    = c_LO + c_EW'(MEM_BYTES);

    localparam logic [2:0]      c_F3_B  = 3'b000;
    localparam logic [2:0]      c_F3_H  = 3'b001;
    localparam logic [2:0]      c_F3_W  = 3'b010;
    localparam logic [2:0]      c_F3_HU = 3'b101;

    logic [c_CNT_W-1:0] r_starve_cnt;
    logic               w_starved;
    logic               w_if_gnt;
    logic               w_d_gnt;

    logic [AWIDTH-1:0]  w_win_addr;
    logic [2:0]         w_win_funct3;
    logic               w_win_we;
    logic [c_EW-1:0]    w_win_addr_ext;
    logic [c_EW-1:0]    w_win_last_ext;
    logic               w_range_fault;
    logic               w_align_fault;
    logic               w_store_fault;
    logic               w_fault;
    logic [DWIDTH-1:0]  w_win_rdata;

    logic               r_if_rvalid;
    logic [DWIDTH-1:0]  r_if_rdata;
    logic               r_if_err;
    logic               r_d_rvalid;
    logic [DWIDTH-1:0]  r_d_rdata;
    logic               r_d_err;

    // ------------------------------------------------------------------
    // Arbitration: data normally wins a collision; a fetch that has been
    // denied STARVE_LIMIT times in a row takes priority. No grants are
    // issued while reset is held so nothing is consumed in a reset cycle.
    // ------------------------------------------------------------------
    assign w_starved = (r_starve_cnt >= c_LIMIT);
    assign w_if_gnt  = !rst && if_req_i && (!d_req_i || w_starved);
    assign w_d_gnt   = !rst && d_req_i && !w_if_gnt;

    assign if_gnt_o  = w_if_gnt;
    assign d_gnt_o   = w_d_gnt;

    // ------------------------------------------------------------------
    // Fault screening on whichever request wins this cycle.
    // ------------------------------------------------------------------
    assign w_win_addr     = w_d_gnt ? d_addr_i   : if_addr_i;
    assign w_win_funct3   = w_d_gnt ? d_funct3_i : c_F3_W;
    assign w_win_we       = w_d_gnt && d_we_i;

    assign w_win_addr_ext = {1'b0, w_win_addr};
    assign w_win_last_ext = w_win_addr_ext + c_EW'(3);

    assign w_range_fault  = (w_win_addr_ext < c_LO) || (w_win_last_ext >= c_HI);
    assign w_align_fault  = ((w_win_funct3 == c_F3_W) && (w_win_addr[1:0] != 2'b00)) ||
                            (((w_win_funct3 == c_F3_H) || (w_win_funct3 == c_F3_HU)) &&
                             w_win_addr[0]);
    // Stores only exist as SB/SH/SW.
    assign w_store_fault  = w_win_we && (w_win_funct3 != c_F3_B) &&
                            (w_win_funct3 != c_F3_H) && (w_win_funct3 != c_F3_W);
    assign w_fault        = (w_if_gnt || w_d_gnt) &&
                            (w_range_fault || w_align_fault || w_store_fault);

    // Only a clean read returns memory data; stores and faults return zero.
    assign w_win_rdata    = (!w_fault && !w_win_we) ? mem_data_i : '0;

    // Drive the memory from the winner; idle, reset and faults keep enables low.
    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        mem_funct3_o   = 3'b000;
        if (w_if_gnt) begin
            mem_addr_o    = if_addr_i;
            mem_funct3_o  = c_F3_W;
            mem_read_en_o = !w_fault;
        end else if (w_d_gnt) begin
            mem_addr_o     = d_addr_i;
            mem_data_o     = d_wdata_i;
            mem_funct3_o   = d_funct3_i;
            mem_read_en_o  = !d_we_i && !w_fault;
            mem_write_en_o = d_we_i && !w_fault;
        end
    end

    // Count consecutive cycles a pending fetch is passed over, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (if_req_i && !w_if_gnt) begin
            if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Capture the response of this cycle's grant for presentation next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_err     <= 1'b0;
        end else begin
            r_if_rvalid <= w_if_gnt;
            r_if_rdata  <= w_if_gnt ? w_win_rdata : '0;
            r_if_err    <= w_if_gnt && w_fault;
            r_d_rvalid  <= w_d_gnt;
            r_d_rdata   <= w_d_gnt ? w_win_rdata : '0;
            r_d_err     <= w_d_gnt && w_fault;
        end
    end

    // A response pending when reset arrives is suppressed immediately rather
    // than one edge later, so a grant just before reset never reports back.
    assign if_rvalid_o = r_if_rvalid && !rst;
    assign if_rdata_o  = rst ? '0 : r_if_rdata;
    assign if_err_o    = r_if_err && !rst;
    assign d_rvalid_o  = r_d_rvalid && !rst;
    assign d_rdata_o   = rst ? '0 : r_d_rdata;
    assign d_err_o     = r_d_err && !rst;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed vector table,
//                hand-written contention/reset sequences, and randomized
//                traffic checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [31:0] BASE  = 32'h01000000;
    localparam int          MEMB  = 4096;
    localparam int          LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
    logic [2:0]  mem_funct3;

    mem_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .MEM_BYTES(MEMB), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_funct3_i(d_funct3), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
        .d_rdata_o(d_rdata), .d_err_o(d_err),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_read_en_o(mem_re),
        .mem_write_en_o(mem_we), .mem_funct3_o(mem_funct3), .mem_data_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared helpers ----------------
    // RISC-V load extension of the 4 bytes starting at the access address.
    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f);
        case (f)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Initial memory image.
    function automatic logic [7:0] img_byte(input int i);
        logic [31:0] w;
        case (i / 4)
            0:       w = 32'h00500093;
            8:       w = 32'hA0000001;
            9:       w = 32'hA0000002;
            10:      w = 32'hA0000003;
            11:      w = 32'hA0000004;
            default: w = 32'h0;
        endcase
        return w[8*(i%4) +: 8];
    endfunction

    // ---------------- memory the arbiter drives ----------------
    logic [7:0] env_mem [MEMB];
    int         env_off;
    logic       env_ok;
    logic       load_img;

    // Combinational read regardless of read_en; junk outside the window.
    always_comb begin
        env_off   = int'(mem_addr - BASE);
        env_ok    = (env_off >= 0) && (env_off <= MEMB - 4);
        mem_rdata = 32'hDEAD0000;
        if (env_ok)
            mem_rdata = ext({env_mem[env_off+3], env_mem[env_off+2],
                             env_mem[env_off+1], env_mem[env_off]}, mem_funct3);
    end

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < MEMB; i++) env_mem[i] <= img_byte(i);
        end else if (mem_we && env_ok) begin
            env_mem[env_off] <= mem_wdata[7:0];
            if (mem_funct3 != 3'b000) env_mem[env_off+1] <= mem_wdata[15:8];
            if (mem_funct3 != 3'b000 && mem_funct3 != 3'b001) begin
                env_mem[env_off+2] <= mem_wdata[23:16];
                env_mem[env_off+3] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [MEMB];
    int          m_starve;
    bit          p_irv, p_drv, p_ierr, p_derr;
    logic [31:0] p_ird, p_drd;
    int          m_win;     // 0 none, 1 fetch, 2 data
    int          n_cmp, n_bad;
    bit          obs_ig, obs_dg, obs_mwe, obs_irv, obs_drv, obs_ierr, obs_derr;
    logic [31:0] obs_ird, obs_drd;

    function automatic bit ref_fault(input logic [31:0] a, input logic [2:0] f, input bit st);
        longint la = longint'(a);
        if (la < longint'(BASE) || la + 3 >= longint'(BASE) + MEMB) return 1'b1;
        if (f == 3'b010 && (a % 4) != 0) return 1'b1;
        if ((f == 3'b001 || f == 3'b101) && (a % 2) != 0) return 1'b1;
        if (st && f > 3'b010) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
        int o = int'(a - BASE);
        return ext({ref_mem[o+3], ref_mem[o+2], ref_mem[o+1], ref_mem[o]}, f);
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] v, input logic [2:0] f);
        int nb = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
        int o  = int'(a - BASE);
        for (int k = 0; k < nb; k++) ref_mem[o+k] = v[8*k +: 8];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock cycle: drive, check last grant's response, check this
    // cycle's grant and memory drive, then advance the model past the edge.
    task automatic cycle(input bit r, input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dwe, input logic [31:0] da,
                         input logic [31:0] dwd, input logic [2:0] df);
        bit          flt;
        logic [31:0] rv;
        rst = r; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_funct3 = df;
        #1;
        obs_irv = if_rvalid; obs_ird = if_rdata; obs_ierr = if_err;
        obs_drv = d_rvalid;  obs_drd = d_rdata;  obs_derr = d_err;
        chk("if_rvalid", if_rvalid, r ? 1'b0 : p_irv);
        chk("if_rdata",  if_rdata,  r ? 32'h0 : p_ird);
        chk("if_err",    if_err,    r ? 1'b0 : p_ierr);
        chk("d_rvalid",  d_rvalid,  r ? 1'b0 : p_drv);
        chk("d_rdata",   d_rdata,   r ? 32'h0 : p_drd);
        chk("d_err",     d_err,     r ? 1'b0 : p_derr);

        m_win = 0;
        if (!r) begin
            if (ir && dr)  m_win = (m_starve >= LIMIT) ? 1 : 2;
            else if (ir)   m_win = 1;
            else if (dr)   m_win = 2;
        end
        flt = (m_win == 1) ? ref_fault(ia, 3'b010, 1'b0) :
              (m_win == 2) ? ref_fault(da, df, dwe) : 1'b0;
        #3;
        obs_ig = if_gnt; obs_dg = d_gnt; obs_mwe = mem_we;
        chk("if_gnt", if_gnt, m_win == 1);
        chk("d_gnt",  d_gnt,  m_win == 2);
        chk("mem_write_en", mem_we, (m_win == 2) && dwe && !flt);
        chk("mem_read_en",  mem_re, ((m_win == 1) || (m_win == 2 && !dwe)) && !flt);
        if (m_win == 0) begin
            chk("idle_addr",   mem_addr,   32'h0);
            chk("idle_data",   mem_wdata,  32'h0);
            chk("idle_funct3", mem_funct3, 3'b000);
        end else if (!flt) begin
            chk("mem_addr",   mem_addr,   (m_win == 1) ? ia : da);
            chk("mem_funct3", mem_funct3, (m_win == 1) ? 3'b010 : df);
            if (m_win == 2) chk("mem_data", mem_wdata, dwd);
        end
        rv = 32'h0;
        if (m_win != 0 && !flt && !(m_win == 2 && dwe))
            rv = (m_win == 1) ? ref_load(ia, 3'b010) : ref_load(da, df);

        @(posedge clk);
        p_irv  = (m_win == 1);          p_drv  = (m_win == 2);
        p_ird  = (m_win == 1) ? rv : 0; p_drd  = (m_win == 2) ? rv : 0;
        p_ierr = (m_win == 1) && flt;   p_derr = (m_win == 2) && flt;
        if (m_win == 2 && dwe && !flt) ref_store(da, dwd, df);
        if (r)                       m_starve = 0;
        else if (ir && m_win != 1)   m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        else                         m_starve = 0;
        #1;
    endtask

    typedef struct {
        bit          r, ir;
        logic [31:0] ia;
        bit          dr, dwe;
        logic [31:0] da, dwd;
        logic [2:0]  df;
        bit          eig, edg, emwe, eirv;
        logic [31:0] eird;
        bit          eierr, edrv;
        logic [31:0] edrd;
        bit          ederr;
    } vec_t;

    vec_t        vt [19];
    bit          exp_f [6];
    logic [2:0]  lf [5];
    bit          pi, pd, rr, rwe;
    logic [31:0] ra_i, ra_d, rwd;
    logic [2:0]  rf;

    initial begin
        n_cmp = 0; n_bad = 0; m_starve = 0;
        p_irv = 0; p_drv = 0; p_ierr = 0; p_derr = 0; p_ird = 0; p_drd = 0;
        for (int i = 0; i < MEMB; i++) ref_mem[i] = img_byte(i);
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        load_img = 1'b1;

        // response columns are what is visible in that row's cycle
        //        r ir ia          dr we da            wdata         f   ig dg mwe irv ird           ierr drv drd           derr
        vt[0]  = '{1,1,BASE,       1,0,BASE,         0,            2,  0,0,0,  0,0,            0,   0,0,            0};
        vt[1]  = '{0,1,BASE,       0,0,0,            0,            0,  1,0,0,  0,0,            0,   0,0,            0};
        vt[2]  = '{0,0,0,          1,1,BASE+32'h10,  32'hDEADBEEF, 2,  0,1,1,  1,32'h00500093, 0,   0,0,            0};
        vt[3]  = '{0,0,0,          1,0,BASE+32'h13,  0,            0,  0,1,0,  0,0,            0,   1,0,            0};
        vt[4]  = '{0,0,0,          1,0,BASE+32'h12,  0,            5,  0,1,0,  0,0,            0,   1,32'hFFFFFFDE, 0};
        vt[5]  = '{0,0,0,          1,0,32'h01000002, 0,            2,  0,1,0,  0,0,            0,   1,32'h0000DEAD, 0};
        vt[6]  = '{0,0,0,          1,1,32'h01000001, 32'h0000CAFE, 1,  0,1,0,  0,0,            0,   1,0,            1};
        vt[7]  = '{0,0,0,          1,0,32'h00FFFFFC, 0,            2,  0,1,0,  0,0,            0,   1,0,            1};
        vt[8]  = '{0,0,0,          1,1,32'h01000FFE, 32'h11111111, 2,  0,1,0,  0,0,            0,   1,0,            1};
        vt[9]  = '{0,0,0,          1,1,32'h01000FFC, 32'h12345678, 2,  0,1,1,  0,0,            0,   1,0,            1};
        vt[10] = '{0,0,0,          1,0,32'h01000FFC, 0,            2,  0,1,0,  0,0,            0,   1,0,            0};
        vt[11] = '{0,0,0,          1,0,32'h01000FFD, 0,            4,  0,1,0,  0,0,            0,   1,32'h12345678, 0};
        vt[12] = '{0,0,0,          1,1,BASE+32'h40,  32'h55555555, 3,  0,1,0,  0,0,            0,   1,0,            1};
        vt[13] = '{0,1,BASE+32'h20,0,0,0,            0,            0,  1,0,0,  0,0,            0,   1,0,            1};
        vt[14] = '{0,1,BASE+32'h24,0,0,0,            0,            0,  1,0,0,  1,32'hA0000001, 0,   0,0,            0};
        vt[15] = '{0,1,BASE+32'h28,0,0,0,            0,            0,  1,0,0,  1,32'hA0000002, 0,   0,0,            0};
        vt[16] = '{0,1,BASE+32'h2C,0,0,0,            0,            0,  1,0,0,  1,32'hA0000003, 0,   0,0,            0};
        vt[17] = '{0,0,0,          0,0,0,            0,            0,  0,0,0,  1,32'hA0000004, 0,   0,0,            0};
        vt[18] = '{0,0,0,          0,0,0,            0,            0,  0,0,0,  0,0,            0,   0,0,            0};

        for (int i = 0; i < 19; i++) begin
            cycle(vt[i].r, vt[i].ir, vt[i].ia, vt[i].dr, vt[i].dwe, vt[i].da, vt[i].dwd, vt[i].df);
            load_img = 1'b0;
            chk($sformatf("v%0d_if_gnt", i),    obs_ig,   vt[i].eig);
            chk($sformatf("v%0d_d_gnt", i),     obs_dg,   vt[i].edg);
            chk($sformatf("v%0d_mem_we", i),    obs_mwe,  vt[i].emwe);
            chk($sformatf("v%0d_if_rvalid", i), obs_irv,  vt[i].eirv);
            chk($sformatf("v%0d_if_rdata", i),  obs_ird,  vt[i].eird);
            chk($sformatf("v%0d_if_err", i),    obs_ierr, vt[i].eierr);
            chk($sformatf("v%0d_d_rvalid", i),  obs_drv,  vt[i].edrv);
            chk($sformatf("v%0d_d_rdata", i),   obs_drd,  vt[i].edrd);
            chk($sformatf("v%0d_d_err", i),     obs_derr, vt[i].ederr);
        end

        // Contention: both held for six cycles -> D,D,D,D,F,D
        exp_f = '{0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, BASE + 32'h20, 1, 0, BASE + 32'h10, 0, 3'b010);
            chk($sformatf("contend%0d_if_gnt", i), obs_ig, exp_f[i]);
            chk($sformatf("contend%0d_d_gnt", i),  obs_dg, !exp_f[i]);
        end

        // Reset mid-operation, with the starvation counter wound up first.
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, BASE, 1, 0, BASE + 32'h10, 0, 3'b010);
            chk($sformatf("prerst%0d_d_gnt", i), obs_dg, 1'b1);
        end
        cycle(1, 1, BASE, 1, 0, BASE + 32'h10, 0, 3'b010);
        chk("rst_cycle_d_rvalid", obs_drv, 1'b0);
        chk("rst_cycle_d_rdata",  obs_drd, 32'h0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("postrst_d_rvalid",  obs_drv, 1'b0);
        chk("postrst_if_rvalid", obs_irv, 1'b0);
        cycle(0, 1, BASE, 1, 0, BASE + 32'h10, 0, 3'b010);
        chk("postrst_starve_clear_d_gnt", obs_dg, 1'b1);

        // Randomized traffic with requesters holding until granted.
        pi = 0; pd = 0; ra_i = 0; ra_d = 0; rwd = 0; rf = 0; rwe = 0;
        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 59) == 0);
            if (!pi && $urandom_range(0, 9) < 6) begin
                pi   = 1;
                ra_i = BASE + 4 * $urandom_range(0, MEMB / 4 - 1);
                if ($urandom_range(0, 9) == 0) ra_i = ra_i + $urandom_range(1, 3);
                if ($urandom_range(0, 19) == 0) ra_i = BASE + MEMB - 4 * $urandom_range(0, 2);
            end
            if (!pd && $urandom_range(0, 9) < 6) begin
                pd  = 1;
                rwe = ($urandom_range(0, 1) == 1);
                rwd = $urandom;
                if (rwe) rf = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
                else     rf = lf[$urandom_range(0, 4)];
                case ($urandom_range(0, 19))
                    0:       ra_d = BASE - $urandom_range(1, 8);
                    1:       ra_d = BASE + MEMB - $urandom_range(1, 8);
                    default: ra_d = BASE + $urandom_range(0, 255);
                endcase
                if ($urandom_range(0, 3) != 0) begin
                    if (rf == 3'b010) ra_d = ra_d & ~32'h3;
                    else if (rf == 3'b001 || rf == 3'b101) ra_d = ra_d & ~32'h1;
                end
            end
            cycle(rr, pi, ra_i, pd, rwe, ra_d, rwd, rf);
            if (m_win == 1) pi = 0;
            if (m_win == 2) pd = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
